fpu_rs_pipe: RTL and testbench

//  Parametrised reservation station for a pipelined FP unit (fmul/fadd class). Holds up to
//  N_ENTRY issued ops and snoops N_CDB result buses for missing operands. Dispatches the oldest

---
 rtl/fpu_rs_pkg.sv | 46 ++++
 rtl/fpu_rs_pipe_wakeup.sv | 29 ++
 rtl/fpu_rs_pipe.sv | 153 +++++++++++++++
 tb/tb_fpu_rs_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_rs_pkg.sv
// Shared types for the FP reservation station: CDB broadcast, operand slot, station entry,
// and the tag-snoop helper used for operand wakeup.
package fpu_rs_pkg;

  localparam int ROB_WIDTH = 6;
  // Upper bound on snooped CDB channels; unused channels are padded invalid.
  localparam int CDB_MAX   = 8;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } rs_opd_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    rs_opd_t [1:0]        opd;
  } rs_entry_t;

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } cdb_hit_t;

  // Walks from the highest channel down so the lowest matching channel supplies the data.
  function automatic cdb_hit_t tag_match_any(input cdb_t [CDB_MAX-1:0] cdb,
                                             input logic [ROB_WIDTH-1:0] tag);
    cdb_hit_t r;
    r = '0;
    for (int k = CDB_MAX - 1; k >= 0; k--) begin
      if (cdb[k].valid && (cdb[k].tag == tag)) begin
        r.hit  = 1'b1;
        r.data = cdb[k].data;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fpu_rs_pipe_wakeup.sv
// Combinational CDB snoop for one operand slot: a waiting operand captures data from the
// lowest CDB channel broadcasting its producer tag.
module rs_wakeup
  import fpu_rs_pkg::*;
#(
  parameter int N_CDB = 2
) (
  input  cdb_t [N_CDB-1:0] cdb,
  input  rs_opd_t          opd_in,
  output rs_opd_t          opd_out
);

  cdb_t [CDB_MAX-1:0] cdb_pad;
  cdb_hit_t           hit;

  always_comb begin
    cdb_pad = '0;
    for (int k = 0; k < N_CDB; k++) begin
      cdb_pad[k] = cdb[k];
    end
    hit     = tag_match_any(cdb_pad, opd_in.tag);
    opd_out = opd_in;
    if (!opd_in.valid && hit.hit) begin
      opd_out.valid = 1'b1;
      opd_out.data  = hit.data;
    end
  end

endmodule

// File: rtl/fpu_rs_pipe.sv
// Reservation station for a pipelined FP core: holds issued ops oldest-first, wakes operands
// from the CDBs, dispatches the oldest ready op and tracks tag/valid through the core pipe.
module fpu_rs_pipe
  import fpu_rs_pkg::*;
#(
  parameter int N_ENTRY = 4,
  parameter int N_CDB   = 2,
  parameter int LATENCY = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [ROB_WIDTH-1:0]         issue_tag,
  input  logic [1:0]                   issue_opd_valid,
  input  logic [2*ROB_WIDTH-1:0]       issue_opd_tag,
  input  logic [63:0]                  issue_opd_data,
  input  logic [N_CDB-1:0]             cdb_valid,
  input  logic [N_CDB*ROB_WIDTH-1:0]   cdb_tag,
  input  logic [N_CDB*32-1:0]          cdb_data,
  output logic                         core_en,
  output logic [31:0]                  core_a,
  output logic [31:0]                  core_b,
  input  logic [31:0]                  core_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ROB_WIDTH-1:0]         out_tag,
  output logic [31:0]                  out_result,
  output logic [$clog2(N_ENTRY+1)-1:0] count
);

  localparam int CW = $clog2(N_ENTRY + 1);
  localparam int IW = $clog2(N_ENTRY);

  // Handshakes: an issue transfers on an edge with issue_valid & issue_ready & !flush; a result
  // transfers on an edge with out_valid & out_ready, and out_valid/out_tag hold until it does.

  cdb_t [N_CDB-1:0]     cdb;
  rs_entry_t            ent_q [N_ENTRY];
  rs_entry_t            ent_w [N_ENTRY];
  rs_entry_t            ent_d [N_ENTRY];
  rs_opd_t              wk_opd [N_ENTRY][2];
  rs_opd_t              iss_opd_raw [2];
  rs_opd_t              iss_opd_w [2];
  rs_entry_t            iss_w;
  logic [N_ENTRY-1:0]   ready;
  logic                 any_ready, adv, dispatch, issue_acc;
  logic [IW-1:0]        disp_idx, wr_idx;
  logic [LATENCY-1:0]   pv_q;
  logic [ROB_WIDTH-1:0] pt_q [LATENCY];
  logic [CW-1:0]        count_q;

  always_comb begin
    cdb = '0;
    for (int k = 0; k < N_CDB; k++) begin
      cdb[k].valid = cdb_valid[k];
      cdb[k].tag   = cdb_tag[k*ROB_WIDTH +: ROB_WIDTH];
      cdb[k].data  = cdb_data[k*32 +: 32];
    end
    for (int j = 0; j < 2; j++) begin
      iss_opd_raw[j].valid = issue_opd_valid[j];
      iss_opd_raw[j].tag   = issue_opd_tag[j*ROB_WIDTH +: ROB_WIDTH];
      iss_opd_raw[j].data  = issue_opd_data[j*32 +: 32];
    end
  end

  for (genvar j = 0; j < 2; j++) begin : g_opd
    for (genvar i = 0; i < N_ENTRY; i++) begin : g_ent
      rs_wakeup #(.N_CDB(N_CDB)) u_wk_ent (
        .cdb(cdb), .opd_in(ent_q[i].opd[j]), .opd_out(wk_opd[i][j])
      );
    end
    rs_wakeup #(.N_CDB(N_CDB)) u_wk_iss (
      .cdb(cdb), .opd_in(iss_opd_raw[j]), .opd_out(iss_opd_w[j])
    );
  end

  // Dispatch sees this cycle's wakeups, so a CDB hit can release an entry immediately.
  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) begin
      ent_w[i]        = ent_q[i];
      ent_w[i].opd[0] = wk_opd[i][0];
      ent_w[i].opd[1] = wk_opd[i][1];
      ready[i]        = ent_q[i].valid & wk_opd[i][0].valid & wk_opd[i][1].valid;
    end
    iss_w.valid  = 1'b1;
    iss_w.tag    = issue_tag;
    iss_w.opd[0] = iss_opd_w[0];
    iss_w.opd[1] = iss_opd_w[1];

    any_ready = 1'b0;
    disp_idx  = '0;
    for (int i = N_ENTRY - 1; i >= 0; i--) begin
      if (ready[i]) begin
        any_ready = 1'b1;
        disp_idx  = IW'(i);
      end
    end

    adv         = !out_valid || out_ready;
    dispatch    = adv && any_ready;
    issue_ready = (count_q < CW'(N_ENTRY)) || dispatch;
    issue_acc   = issue_valid && issue_ready && !flush;
    wr_idx      = IW'(count_q - CW'(dispatch));

    for (int i = 0; i < N_ENTRY; i++) begin
      if (dispatch && (IW'(i) >= disp_idx)) begin
        if (i == N_ENTRY - 1) ent_d[i] = '0;
        else                  ent_d[i] = ent_w[(i + 1) % N_ENTRY];
      end else begin
        ent_d[i] = ent_w[i];
      end
      if (issue_acc && (wr_idx == IW'(i))) ent_d[i] = iss_w;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_ENTRY; i++) ent_q[i] <= '0;
      count_q <= '0;
      pv_q    <= '0;
    end else if (flush) begin
      for (int i = 0; i < N_ENTRY; i++) ent_q[i] <= '0;
      count_q <= '0;
      pv_q    <= '0;
    end else begin
      for (int i = 0; i < N_ENTRY; i++) ent_q[i] <= ent_d[i];
      count_q <= count_q + CW'(issue_acc) - CW'(dispatch);
      if (adv) begin
        pv_q[0] <= dispatch;
        for (int s = 1; s < LATENCY; s++) pv_q[s] <= pv_q[s-1];
      end
    end
  end

  // Tags ride alongside the valid bits; they carry no meaning while their valid is low.
  always_ff @(posedge clk) begin
    if (adv) begin
      pt_q[0] <= ent_w[disp_idx].tag;
      for (int s = 1; s < LATENCY; s++) pt_q[s] <= pt_q[s-1];
    end
  end

  assign core_en    = adv;
  assign core_a     = ent_w[disp_idx].opd[0].data;
  assign core_b     = ent_w[disp_idx].opd[1].data;
  assign out_valid  = pv_q[LATENCY-1];
  assign out_tag    = pt_q[LATENCY-1];
  assign out_result = core_result;
  assign count      = count_q;

endmodule

// File: tb/tb_fpu_rs_pipe.sv
// Directed bench for fpu_rs_pipe (N_ENTRY=4, N_CDB=2, LATENCY=3) with an adder standing in
// for the external core.
module tb_fpu_rs_pipe;
  import fpu_rs_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic flush, issue_valid, issue_ready;
  logic [ROB_WIDTH-1:0] issue_tag;
  logic [1:0] issue_opd_valid;
  logic [2*ROB_WIDTH-1:0] issue_opd_tag;
  logic [63:0] issue_opd_data;
  logic [1:0] cdb_valid;
  logic [2*ROB_WIDTH-1:0] cdb_tag;
  logic [63:0] cdb_data;
  logic core_en;
  logic [31:0] core_a, core_b, core_result;
  logic out_valid, out_ready;
  logic [ROB_WIDTH-1:0] out_tag;
  logic [31:0] out_result;
  logic [2:0] count;
  logic [31:0] core_pipe [3];

  int total = 0;
  int bad = 0;

  fpu_rs_pipe #(.N_ENTRY(4), .N_CDB(2), .LATENCY(3)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .issue_opd_valid(issue_opd_valid), .issue_opd_tag(issue_opd_tag),
    .issue_opd_data(issue_opd_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .core_en(core_en), .core_a(core_a), .core_b(core_b), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_result(out_result), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_en) begin
      core_pipe[0] <= core_a + core_b;
      core_pipe[1] <= core_pipe[0];
      core_pipe[2] <= core_pipe[1];
    end
  end
  assign core_result = core_pipe[2];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle;
    flush = 1'b0;
    issue_valid = 1'b0;
    issue_tag = '0;
    issue_opd_valid = 2'b00;
    issue_opd_tag = '0;
    issue_opd_data = '0;
    cdb_valid = 2'b00;
    cdb_tag = '0;
    cdb_data = '0;
    out_ready = 1'b1;
  endtask

  task automatic drive_issue(input logic [ROB_WIDTH-1:0] tag,
                             input logic v0, input logic [ROB_WIDTH-1:0] t0, input logic [31:0] d0,
                             input logic v1, input logic [ROB_WIDTH-1:0] t1, input logic [31:0] d1);
    issue_valid = 1'b1;
    issue_tag = tag;
    issue_opd_valid = {v1, v0};
    issue_opd_tag = {t1, t0};
    issue_opd_data = {d1, d0};
  endtask

  task automatic drive_cdb(input int k, input logic [ROB_WIDTH-1:0] tag, input logic [31:0] data);
    cdb_valid[k] = 1'b1;
    cdb_tag[k*ROB_WIDTH +: ROB_WIDTH] = tag;
    cdb_data[k*32 +: 32] = data;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    idle();
    settle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready got=%b exp=1", issue_ready); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_ready_issue;
    drive_issue(6'd5, 1'b1, 6'd0, 32'h3f800000, 1'b1, 6'd0, 32'h40000000);
    settle();
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL ready_issue_ready got=%b exp=1", issue_ready); end
    tick();
    idle();
    settle();
    total++; if (count !== 3'd1) begin bad++; $display("FAIL ready_count1 got=%0d exp=1", count); end
    total++; if (core_a !== 32'h3f800000) begin bad++; $display("FAIL ready_core_a got=%h exp=3f800000", core_a); end
    total++; if (core_b !== 32'h40000000) begin bad++; $display("FAIL ready_core_b got=%h exp=40000000", core_b); end
    tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL ready_count0 got=%0d exp=0", count); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ready_early_out got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_tag !== 6'd5) begin bad++; $display("FAIL ready_out got=%b/%0d exp=1/5", out_valid, out_tag); end
    total++; if (out_result !== 32'h7f800000) begin bad++; $display("FAIL ready_result got=%h exp=7f800000", out_result); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ready_out_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_wakeup_order;
    drive_issue(6'd1, 1'b1, 6'd0, 32'h1, 1'b0, 6'd9, 32'h0);
    tick();
    drive_issue(6'd2, 1'b1, 6'd0, 32'h2, 1'b1, 6'd0, 32'h3);
    tick();
    idle();
    settle();
    total++; if (count !== 3'd2) begin bad++; $display("FAIL order_count2 got=%0d exp=2", count); end
    total++; if (core_a !== 32'h2 || core_b !== 32'h3) begin bad++; $display("FAIL order_first got=%h/%h exp=2/3", core_a, core_b); end
    tick();
    drive_cdb(0, 6'd7, 32'hdead0000);
    drive_cdb(1, 6'd9, 32'h40400000);
    settle();
    total++; if (core_a !== 32'h1 || core_b !== 32'h40400000) begin bad++; $display("FAIL order_wake got=%h/%h exp=1/40400000", core_a, core_b); end
    tick();
    idle();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL order_count0 got=%0d exp=0", count); end
    tick();
    total++; if (out_valid !== 1'b1 || out_tag !== 6'd2 || out_result !== 32'h5) begin bad++; $display("FAIL order_out1 got=%b/%0d/%h exp=1/2/5", out_valid, out_tag, out_result); end
    tick();
    total++; if (out_valid !== 1'b1 || out_tag !== 6'd1 || out_result !== 32'h40400001) begin bad++; $display("FAIL order_out2 got=%b/%0d/%h exp=1/1/40400001", out_valid, out_tag, out_result); end
    tick();
  endtask

  task automatic test_cdb_priority;
    drive_issue(6'd3, 1'b0, 6'd12, 32'h0, 1'b1, 6'd0, 32'h100);
    tick();
    idle();
    drive_cdb(0, 6'd12, 32'ha);
    drive_cdb(1, 6'd12, 32'hb);
    settle();
    total++; if (core_a !== 32'ha) begin bad++; $display("FAIL prio_core_a got=%h exp=a", core_a); end
    tick();
    idle();
    tick(); tick();
    total++; if (out_tag !== 6'd3 || out_result !== 32'h10a) begin bad++; $display("FAIL prio_out got=%0d/%h exp=3/10a", out_tag, out_result); end
    tick();
  endtask

  task automatic test_same_cycle;
    drive_issue(6'd20, 1'b1, 6'd0, 32'h1, 1'b0, 6'd40, 32'h0);
    tick();
    drive_issue(6'd21, 1'b0, 6'd40, 32'h0, 1'b1, 6'd0, 32'h2);
    drive_cdb(1, 6'd40, 32'h9);
    settle();
    total++; if (issue_ready !== 1'b1 || core_a !== 32'h1 || core_b !== 32'h9) begin bad++; $display("FAIL same_disp got=%b/%h/%h exp=1/1/9", issue_ready, core_a, core_b); end
    tick();
    idle();
    settle();
    total++; if (count !== 3'd1) begin bad++; $display("FAIL same_count got=%0d exp=1", count); end
    total++; if (core_a !== 32'h9 || core_b !== 32'h2) begin bad++; $display("FAIL same_bypass got=%h/%h exp=9/2", core_a, core_b); end
    tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL same_count0 got=%0d exp=0", count); end
    tick(); tick(); tick();
  endtask

  task automatic test_fill;
    for (int i = 0; i < 4; i++) begin
      drive_issue(6'(10 + i), 1'b0, 6'(30 + i), 32'h0, 1'b1, 6'd0, 32'(i));
      tick();
    end
    drive_issue(6'd14, 1'b0, 6'd34, 32'h0, 1'b1, 6'd0, 32'h4);
    settle();
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b exp=0", issue_ready); end
    tick();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count_hold got=%0d exp=4", count); end
    drive_cdb(0, 6'd32, 32'h100);
    settle();
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL fill_wake_ready got=%b exp=1", issue_ready); end
    total++; if (core_a !== 32'h100 || core_b !== 32'h2) begin bad++; $display("FAIL fill_wake_disp got=%h/%h exp=100/2", core_a, core_b); end
    tick();
    idle();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count_swap got=%0d exp=4", count); end
    drive_cdb(0, 6'd33, 32'h1000);
    drive_cdb(1, 6'd34, 32'h2000);
    settle();
    total++; if (core_a !== 32'h1000 || core_b !== 32'h3) begin bad++; $display("FAIL fill_idx2 got=%h/%h exp=1000/3", core_a, core_b); end
    tick();
    idle();
    settle();
    total++; if (core_a !== 32'h2000 || core_b !== 32'h4) begin bad++; $display("FAIL fill_idx3 got=%h/%h exp=2000/4", core_a, core_b); end
    tick();
    drive_cdb(0, 6'd30, 32'h0);
    drive_cdb(1, 6'd31, 32'h0);
    tick();
    idle();
    settle();
    total++; if (core_b !== 32'h1) begin bad++; $display("FAIL fill_last got=%h exp=1", core_b); end
    tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL fill_drained got=%0d exp=0", count); end
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_back_to_back;
    drive_issue(6'd21, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2);
    tick();
    drive_issue(6'd22, 1'b1, 6'd0, 32'h3, 1'b1, 6'd0, 32'h4);
    tick();
    drive_issue(6'd23, 1'b1, 6'd0, 32'h5, 1'b1, 6'd0, 32'h6);
    out_ready = 1'b0;
    tick();
    issue_valid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive_issue(6'd24, 1'b1, 6'd0, 32'h7, 1'b1, 6'd0, 32'h8);
      settle();
      total++; if (out_valid !== 1'b1 || out_tag !== 6'd21) begin bad++; $display("FAIL bp_hold c=%0d got=%b/%0d exp=1/21", c, out_valid, out_tag); end
      total++; if (core_en !== 1'b0) begin bad++; $display("FAIL bp_core_en c=%0d got=%b exp=0", c, core_en); end
      tick();
      issue_valid = 1'b0;
    end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL bp_count got=%0d exp=1", count); end
    out_ready = 1'b1;
    settle();
    total++; if (out_tag !== 6'd21 || out_result !== 32'h3) begin bad++; $display("FAIL bp_rel0 got=%0d/%h exp=21/3", out_tag, out_result); end
    tick();
    total++; if (out_valid !== 1'b1 || out_tag !== 6'd22 || out_result !== 32'h7) begin bad++; $display("FAIL bp_rel1 got=%b/%0d/%h exp=1/22/7", out_valid, out_tag, out_result); end
    tick();
    total++; if (out_valid !== 1'b1 || out_tag !== 6'd23 || out_result !== 32'hb) begin bad++; $display("FAIL bp_rel2 got=%b/%0d/%h exp=1/23/b", out_valid, out_tag, out_result); end
    tick();
    total++; if (out_valid !== 1'b1 || out_tag !== 6'd24 || out_result !== 32'hf) begin bad++; $display("FAIL bp_rel3 got=%b/%0d/%h exp=1/24/f", out_valid, out_tag, out_result); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush;
    drive_issue(6'd40, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h1);
    tick();
    drive_issue(6'd41, 1'b1, 6'd0, 32'h2, 1'b1, 6'd0, 32'h2);
    tick();
    drive_issue(6'd42, 1'b0, 6'd50, 32'h0, 1'b1, 6'd0, 32'h0);
    tick();
    drive_issue(6'd43, 1'b0, 6'd50, 32'h0, 1'b1, 6'd0, 32'h0);
    tick();
    total++; if (count !== 3'd2 || out_valid !== 1'b1 || out_tag !== 6'd40) begin bad++; $display("FAIL flush_pre got=%0d/%b/%0d exp=2/1/40", count, out_valid, out_tag); end
    drive_issue(6'd44, 1'b1, 6'd0, 32'h4, 1'b1, 6'd0, 32'h4);
    flush = 1'b1;
    tick();
    idle();
    total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear got=%0d/%b exp=0/0", count, out_valid); end
    drive_cdb(0, 6'd50, 32'h50);
    for (int c = 0; c < 4; c++) begin
      tick();
      idle();
      total++; if (out_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL flush_drop c=%0d got=%b/%0d exp=0/0", c, out_valid, count); end
    end
  endtask

  task automatic test_reset_mid;
    drive_issue(6'd60, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2);
    tick();
    drive_issue(6'd61, 1'b0, 6'd55, 32'h0, 1'b1, 6'd0, 32'h0);
    out_ready = 1'b0;
    tick();
    idle();
    out_ready = 1'b0;
    tick(); tick();
    total++; if (out_valid !== 1'b1 || count !== 3'd1) begin bad++; $display("FAIL rstmid_pre got=%b/%0d exp=1/1", out_valid, count); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || count !== 3'd0 || issue_ready !== 1'b1) begin bad++; $display("FAIL rstmid got=%b/%0d/%b exp=0/0/1", out_valid, count, issue_ready); end
    tick();
    reset_n = 1'b1;
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_ready_issue();
    test_wakeup_order();
    test_cdb_priority();
    test_same_cycle();
    test_fill();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
